fir_block_scheduler: RTL

// Sequencer/configurator for the block-parallel FIR core. Gathers PARALLELISM serial input samples into a block

---
 rtl/fir_block_scheduler.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fir_block_scheduler.sv
// -----------------------------------------------------------------------------
// fir_block_scheduler
//
// Purpose:
//   Sequencer and configurator for a block-parallel FIR core.
//   - Collects PARALLELISM serial input samples into one block.
//   - Issues the block to the core with a one-cycle enable.
//   - Waits CORE_LAT cycles for the core to produce its results.
//   - Re-serializes the PARALLELISM results under valid/ready.
//   Only one block is in flight at a time. The scheduler also owns the core's
//   coefficient bank. Writes always land in a shadow bank. A commit request
//   copies the shadow bank into the active bank, but only at the next block
//   issue, so a block never sees a half-updated bank.
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset_n      asynchronous active-low reset
//   i_data/i_valid/o_ready
//                  serial input sample stream
//   o_core_data    block to the core, element [0] is the oldest sample
//                  (packed, element i at [i*NB_IN +: NB_IN])
//   o_core_en      one-cycle block issue strobe
//   i_core_result  core results, sampled CORE_LAT cycles after o_core_en
//                  (packed, element i at [i*NB_OUT +: NB_OUT])
//   o_coeffs       active coefficient bank
//                  (packed, tap k at [k*NB_COEFFS +: NB_COEFFS])
//   i_coeff_wr/i_coeff_addr/i_coeff_data
//                  shadow-bank write port
//   i_coeff_commit request a shadow->active copy at the next issue
//   o_data/o_valid/i_ready
//                  serialized result stream
//   o_busy         high whenever the scheduler is not gathering samples
// -----------------------------------------------------------------------------
module fir_block_scheduler #(
    parameter int NB_IN       = 8,
    parameter int NB_COEFFS   = 8,
    parameter int N_COEFFS    = 8,
    parameter int PARALLELISM = 2,
    parameter int CORE_LAT    = 2,
    parameter int NB_OUT      = NB_IN + NB_COEFFS + $clog2(N_COEFFS),
    parameter int ADDR_W      = $clog2(N_COEFFS)
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic [NB_IN-1:0]              i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [NB_IN*PARALLELISM-1:0]  o_core_data,
    output logic                          o_core_en,
    input  logic [NB_OUT*PARALLELISM-1:0] i_core_result,
    output logic [NB_COEFFS*N_COEFFS-1:0] o_coeffs,
    input  logic                          i_coeff_wr,
    input  logic [ADDR_W-1:0]             i_coeff_addr,
    input  logic [NB_COEFFS-1:0]          i_coeff_data,
    input  logic                          i_coeff_commit,
    output logic [NB_OUT-1:0]             o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_busy
);

    localparam int CNT_W  = $clog2(PARALLELISM);
    localparam int WAIT_W = $clog2(CORE_LAT + 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]     fill_cnt;
    logic [CNT_W-1:0]     drain_idx;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 armed;
    logic                 commit_pending;

    logic [NB_IN-1:0]     core_data   [PARALLELISM];
    logic [NB_OUT-1:0]    out_buf     [PARALLELISM];
    logic [NB_COEFFS-1:0] shadow      [N_COEFFS];
    logic [NB_COEFFS-1:0] shadow_next [N_COEFFS];
    logic [NB_COEFFS-1:0] active      [N_COEFFS];

    logic accept;
    logic out_fire;
    logic last_sample;
    logic last_drain;
    logic wait_done;
    logic addr_ok;

    assign accept      = o_ready & i_valid;
    assign out_fire    = o_valid & i_ready;
    assign last_sample = (fill_cnt == CNT_W'(PARALLELISM - 1));
    assign last_drain  = (drain_idx == CNT_W'(PARALLELISM - 1));
    assign wait_done   = (wait_cnt == '0);
    // The address port can encode more values than there are taps when
    // N_COEFFS is not a power of two; those writes are dropped.
    assign addr_ok     = ({1'b0, i_coeff_addr} < (ADDR_W + 1)'(N_COEFFS));

    // Flatten the internal arrays onto the packed core-facing ports.
    for (genvar g = 0; g < PARALLELISM; g++) begin : g_core_data
        assign o_core_data[g*NB_IN +: NB_IN] = core_data[g];
    end

    for (genvar k = 0; k < N_COEFFS; k++) begin : g_coeffs
        assign o_coeffs[k*NB_COEFFS +: NB_COEFFS] = active[k];
    end

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded handshake outputs. o_ready is
    // additionally gated by 'armed' so the input port only opens on the first
    // clock after reset has been released.
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_core_en  = 1'b0;
        o_valid    = 1'b0;
        o_busy     = 1'b1;
        o_data     = '0;
        case (state)
            ST_FILL: begin
                o_ready = armed;
                o_busy  = 1'b0;
                if (accept && last_sample) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_core_en  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_valid = 1'b1;
                o_data  = out_buf[drain_idx];
                if (out_fire && last_drain) begin
                    state_next = ST_FILL;
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // Input gathering. Samples are stored in arrival order so slot 0 always
    // holds the oldest sample of the block. The fill counter wraps to zero as
    // soon as the block is complete, ready for the block after the drain.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            armed    <= 1'b0;
            fill_cnt <= '0;
            for (int i = 0; i < PARALLELISM; i++) begin
                core_data[i] <= '0;
            end
        end else begin
            armed <= 1'b1;
            if (accept) begin
                core_data[fill_cnt] <= i_data;
                fill_cnt            <= last_sample ? '0 : fill_cnt + 1'b1;
            end
        end
    end

    // Core latency timer and result capture. The counter is loaded during the
    // issue cycle so that the result capture lands exactly CORE_LAT cycles
    // after the o_core_en cycle.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt <= '0;
            for (int i = 0; i < PARALLELISM; i++) begin
                out_buf[i] <= '0;
            end
        end else begin
            if (state == ST_ISSUE) begin
                wait_cnt <= WAIT_W'(CORE_LAT - 1);
            end else if (state == ST_WAIT) begin
                if (wait_done) begin
                    for (int i = 0; i < PARALLELISM; i++) begin
                        out_buf[i] <= i_core_result[i*NB_OUT +: NB_OUT];
                    end
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
            end
        end
    end

    // Output serializer index; it only moves on an accepted handshake so the
    // current word is held for as long as the consumer stalls.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            drain_idx <= '0;
        end else if (out_fire) begin
            drain_idx <= last_drain ? '0 : drain_idx + 1'b1;
        end
    end

    // Shadow bank with this cycle's write folded in. Using this forwarded
    // view for the commit copy means a write in the same cycle as a commit
    // (or in the issue cycle itself) is part of what gets committed.
    always_comb begin
        shadow_next = shadow;
        if (i_coeff_wr && addr_ok) begin
            shadow_next[i_coeff_addr] = i_coeff_data;
        end
    end

    // Coefficient banks. The active bank only changes at the end of the issue
    // cycle, so the block being issued still sees the old bank and the new
    // one appears on o_coeffs the following cycle. Any number of commit
    // requests before an issue collapse into the single pending flag.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            commit_pending <= 1'b0;
            for (int k = 0; k < N_COEFFS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            shadow <= shadow_next;
            if (state == ST_ISSUE) begin
                if (commit_pending || i_coeff_commit) begin
                    active <= shadow_next;
                end
                commit_pending <= 1'b0;
            end else if (i_coeff_commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

endmodule
